alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synchronous self-checking result sink for the ALU datapath. It sits on the output side of any ALU unit under test (OR, AND, XOR, ADD). Each cycle it samples an operand pair and the unit's result, and compares the result against an internal reference model. It keeps pass/fail statistics and the first failing vector so that a run can be judged in hardware without a simulator monitor.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width in bits.
- `CNT_W`, 8: width of the vector and error counters.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` in 1: begin a new checking run; clears the statistics.
- `op` in 2: operation the unit under test executes: 00 OR, 01 AND, 10 XOR, 11 ADD.
- `in_valid` in 1: `x`/`y`/`z` hold a vector to check this cycle.
- `in_last` in 1: qualifies the final vector of the run; meaningful only with `in_valid`.
- `x`, `y` in WIDTH: operands applied to the unit.
- `z` in WIDTH: result produced by the unit.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `pass` out 1: `done` && `err_count`==0.
- `vec_count` out CNT_W: vectors checked in this run.
- `err_count` out CNT_W: mismatching vectors in this run.
- `first_err_idx` out CNT_W: index of the first mismatch; 0 if none.
- `first_err_x`, `first_err_y`, `first_err_z` out WIDTH: captured operands and result of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start`=1 → RUN and clear all counters and capture registers. `in_valid` is ignored in IDLE, including the cycle in which `start` is high.
- RUN:
  - On `in_valid`=1, compute expected = f(`op`, `x`, `y`). ADD is truncated to WIDTH bits (carry discarded).
  - Increment `vec_count`.
  - If `z` != expected, increment `err_count`. If this is the first error, latch `x`/`y`/`z` and set `first_err_idx` to the pre-increment `vec_count` (0-based).
  - `in_valid` && `in_last` → DONE after the vector is checked.
  - `start` in RUN is ignored.
- DONE: all outputs hold. `start`=1 → RUN with cleared statistics (restart). `in_valid` is ignored.
- Counters saturate at 2^CNT_W−1 and never wrap. Once `vec_count` saturates, further mismatches still increment `err_count` up to its own saturation.
- `op` is sampled per vector, so it may change between vectors.
- Reset values: state IDLE, `busy`=0, `done`=0, `pass`=0, and all counters and capture registers 0.

## Timing
- Comparison is combinational on the sampling edge. Counters and captures are visible the cycle after the `in_valid` cycle.
- `done` rises the cycle after the `in_last` vector. The counts shown with `done` include that vector.
- Throughput: one vector per cycle, with no backpressure.
- `rst_n` low during RUN aborts the run. State returns to IDLE and all outputs clear on that edge, and statistics are lost.
- `rst_n` low has priority over `start`.

## Structure
- Shared header `alu_defs.vh` holds the opcode constants `ALU_OR`, `ALU_AND`, `ALU_XOR`, `ALU_ADD` and the FSM state encodings. The ALU units include the same header.
- One sub-module, `alu_ref_model`: combinational expected result from (`op`, `x`, `y`). It is reusable by other checkers.
- The top level contains the FSM, saturating counters and capture registers.

## Test plan
- OR pass run: start, `op`=00, vectors (1101, 0111, z=1111), (1101, 0101, 1101), (1101, 1010, 1111), and last (1111, 0001, 1111). Required: `done` with `vec_count`=4, `err_count`=0, `pass`=1.
- Error capture: `op`=00, vectors (0000, 0101, 0101), (0000, 1111, 1110), and last (1111, 0001, 0000). Required: `err_count`=2, `first_err_idx`=1, `first_err_x/y/z`=0000/1111/1110, `pass`=0.
- ADD truncation: `op`=11, (1111, 0001, z=0000) as the only vector with `in_last`. Required: `pass`=1.
- Restart and ignore rules:
  - `start` and `in_valid` in the same IDLE cycle: the vector is not counted.
  - `start` during RUN: no effect.
  - `start` in DONE: counters clear and `busy`=1 the next cycle.
- Reset mid-run: after 3 vectors, `rst_n`=0 for one cycle. Required: IDLE, with all outputs 0 the next cycle.
- Saturation: CNT_W=2, 6 failing vectors. Required: `vec_count`=3, `err_count`=3, `first_err_idx`=0.

Source files
------------

// File: rtl/alu_result_checker_pkg.sv
// Shared opcode and FSM encodings for the ALU result checker and ALU units.
package alu_result_checker_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ALU_OR  = 2'b00,
    ALU_AND = 2'b01,
    ALU_XOR = 2'b10,
    ALU_ADD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } chk_state_e;

endpackage

// File: rtl/alu_result_checker_ref_model.sv
// Combinational reference model: expected ALU result for (op, x, y).
module alu_ref_model
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] expected_c
);

  // Select the operation; ADD keeps only the low WIDTH bits.
  always_comb begin
    expected_c = '0;
    case (alu_op_e'(op))
      ALU_OR:  expected_c = x | y;
      ALU_AND: expected_c = x & y;
      ALU_XOR: expected_c = x ^ y;
      ALU_ADD: expected_c = x + y;
      default: expected_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking ALU result sink: FSM, saturating statistics, first-error capture.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y,
  output logic [WIDTH-1:0] first_err_z
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state, next_state;
  logic             clear, check, mismatch, capture;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] vec_next, err_next;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op         (op),
    .x          (x),
    .y          (y),
    .expected_c (expected)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state plus check/clear strobes and next counter values.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    check      = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        next_state = ST_RUN;
        clear      = 1'b1;
      end
      ST_RUN: if (in_valid) begin
        check = 1'b1;
        if (in_last) next_state = ST_DONE;
      end
      ST_DONE: if (start) begin
        next_state = ST_RUN;
        clear      = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase

    mismatch = check && (z != expected);
    capture  = mismatch && (err_count == '0);

    vec_next = vec_count;
    err_next = err_count;
    if (clear) begin
      vec_next = '0;
      err_next = '0;
    end else begin
      if (check && vec_count != CNT_MAX)    vec_next = vec_count + CNT_W'(1);
      if (mismatch && err_count != CNT_MAX) err_next = err_count + CNT_W'(1);
    end
  end

  // Registered outputs, statistics and first-error capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_x   <= '0;
      first_err_y   <= '0;
      first_err_z   <= '0;
    end else begin
      busy      <= (next_state == ST_RUN);
      done      <= (next_state == ST_DONE);
      pass      <= (next_state == ST_DONE) && (err_next == '0);
      vec_count <= vec_next;
      err_count <= err_next;
      if (clear) begin
        first_err_idx <= '0;
        first_err_x   <= '0;
        first_err_y   <= '0;
        first_err_z   <= '0;
      end else if (capture) begin
        first_err_idx <= vec_count;
        first_err_x   <= x;
        first_err_y   <= y;
        first_err_z   <= z;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed self-checking bench for alu_result_checker (default and CNT_W=2 instances).
module tb_alu_result_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, in_last;
  logic [1:0]       op;
  logic [WIDTH-1:0] x, y, z;

  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
  logic [WIDTH-1:0] first_err_x, first_err_y, first_err_z;

  logic             s_busy, s_done, s_pass;
  logic [SAT_W-1:0] s_vec, s_err, s_idx;
  logic [WIDTH-1:0] s_fx, s_fy, s_fz;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_valid(in_valid),
    .in_last(in_last), .x(x), .y(y), .z(z), .busy(busy), .done(done),
    .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_x(first_err_x),
    .first_err_y(first_err_y), .first_err_z(first_err_z)
  );

  alu_result_checker #(.WIDTH(WIDTH), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_valid(in_valid),
    .in_last(in_last), .x(x), .y(y), .z(z), .busy(s_busy), .done(s_done),
    .pass(s_pass), .vec_count(s_vec), .err_count(s_err),
    .first_err_idx(s_idx), .first_err_x(s_fx),
    .first_err_y(s_fy), .first_err_z(s_fz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] r, input logic last);
    op = o; x = a; y = b; z = r; in_valid = 1'b1; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, pass}); else n_pass++;
    n_total++; if ({vec_count, err_count, first_err_idx} !== 24'h0) $display("FAIL reset_counts got %h want 000000", {vec_count, err_count, first_err_idx}); else n_pass++;
    n_total++; if ({first_err_x, first_err_y, first_err_z} !== 12'h0) $display("FAIL reset_capture got %h want 000", {first_err_x, first_err_y, first_err_z}); else n_pass++;
  endtask

  task automatic test_or_pass();
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("FAIL or_busy got %b want 1", busy); else n_pass++;
    send(2'b00, 4'b1101, 4'b0111, 4'b1111, 1'b0);
    send(2'b00, 4'b1101, 4'b0101, 4'b1101, 1'b0);
    send(2'b00, 4'b1101, 4'b1010, 4'b1111, 1'b0);
    n_total++; if (done !== 1'b0 || vec_count !== 8'd3) $display("FAIL or_mid got done=%b vec=%0d want done=0 vec=3", done, vec_count); else n_pass++;
    send(2'b00, 4'b1111, 4'b0001, 4'b1111, 1'b1);
    n_total++; if ({busy, done, pass} !== 3'b011) $display("FAIL or_flags got %b want 011", {busy, done, pass}); else n_pass++;
    n_total++; if (vec_count !== 8'd4 || err_count !== 8'd0) $display("FAIL or_counts got vec=%0d err=%0d want vec=4 err=0", vec_count, err_count); else n_pass++;
    tick();
    n_total++; if (done !== 1'b1 || vec_count !== 8'd4) $display("FAIL or_hold got done=%b vec=%0d want done=1 vec=4", done, vec_count); else n_pass++;
  endtask

  task automatic test_error_capture();
    pulse_start();
    n_total++; if (busy !== 1'b1 || vec_count !== 8'd0) $display("FAIL err_restart got busy=%b vec=%0d want busy=1 vec=0", busy, vec_count); else n_pass++;
    send(2'b00, 4'b0000, 4'b0101, 4'b0101, 1'b0);
    send(2'b00, 4'b0000, 4'b1111, 4'b1110, 1'b0);
    send(2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1);
    n_total++; if (vec_count !== 8'd3 || err_count !== 8'd2) $display("FAIL err_counts got vec=%0d err=%0d want vec=3 err=2", vec_count, err_count); else n_pass++;
    n_total++; if (first_err_idx !== 8'd1) $display("FAIL err_idx got %0d want 1", first_err_idx); else n_pass++;
    n_total++; if ({first_err_x, first_err_y, first_err_z} !== 12'b0000_1111_1110) $display("FAIL err_capture got %b want 000011111110", {first_err_x, first_err_y, first_err_z}); else n_pass++;
    n_total++; if ({done, pass} !== 2'b10) $display("FAIL err_pass got done/pass=%b want 10", {done, pass}); else n_pass++;
  endtask

  task automatic test_add_trunc();
    pulse_start();
    send(2'b11, 4'b1111, 4'b0001, 4'b0000, 1'b1);
    n_total++; if ({done, pass} !== 2'b11) $display("FAIL add_pass got done/pass=%b want 11", {done, pass}); else n_pass++;
    n_total++; if (vec_count !== 8'd1 || err_count !== 8'd0) $display("FAIL add_counts got vec=%0d err=%0d want vec=1 err=0", vec_count, err_count); else n_pass++;
  endtask

  task automatic test_mixed_ops();
    pulse_start();
    send(2'b01, 4'b1100, 4'b1010, 4'b1000, 1'b0);
    send(2'b10, 4'b1100, 4'b1010, 4'b0111, 1'b0);
    send(2'b11, 4'b0011, 4'b0100, 4'b0111, 1'b1);
    n_total++; if (vec_count !== 8'd3 || err_count !== 8'd1) $display("FAIL mix_counts got vec=%0d err=%0d want vec=3 err=1", vec_count, err_count); else n_pass++;
    n_total++; if (first_err_idx !== 8'd1 || {first_err_x, first_err_y, first_err_z} !== 12'b1100_1010_0111) $display("FAIL mix_capture got idx=%0d xyz=%b want idx=1 xyz=110010100111", first_err_idx, {first_err_x, first_err_y, first_err_z}); else n_pass++;
  endtask

  task automatic test_restart_rules();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    op = 2'b00; x = 4'b0001; y = 4'b0010; z = 4'b0011;
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_total++; if ({busy, done} !== 2'b10 || vec_count !== 8'd0) $display("FAIL idle_ignore got busy/done=%b vec=%0d want 10 vec=0", {busy, done}, vec_count); else n_pass++;
    start = 1'b1;
    send(2'b00, 4'b0001, 4'b0010, 4'b0011, 1'b0);
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || vec_count !== 8'd1) $display("FAIL run_start_ignored got busy=%b vec=%0d want busy=1 vec=1", busy, vec_count); else n_pass++;
    send(2'b00, 4'b0100, 4'b0010, 4'b0000, 1'b1);
    n_total++; if (done !== 1'b1 || vec_count !== 8'd2 || err_count !== 8'd1) $display("FAIL restart_pre got done=%b vec=%0d err=%0d want done=1 vec=2 err=1", done, vec_count, err_count); else n_pass++;
    in_valid = 1'b1; x = 4'b0000; y = 4'b0000; z = 4'b1111;
    pulse_start();
    in_valid = 1'b0;
    n_total++; if ({busy, done, pass} !== 3'b100) $display("FAIL restart_flags got %b want 100", {busy, done, pass}); else n_pass++;
    n_total++; if ({vec_count, err_count, first_err_idx} !== 24'h0 || first_err_z !== 4'b0000) $display("FAIL restart_clear got %h z=%b want 000000 z=0000", {vec_count, err_count, first_err_idx}, first_err_z); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    send(2'b00, 4'b0001, 4'b0001, 4'b0001, 1'b0);
    send(2'b00, 4'b0010, 4'b0001, 4'b0000, 1'b0);
    send(2'b00, 4'b0100, 4'b0001, 4'b0101, 1'b0);
    n_total++; if (vec_count !== 8'd3 || err_count !== 8'd1) $display("FAIL abort_pre got vec=%0d err=%0d want vec=3 err=1", vec_count, err_count); else n_pass++;
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    n_total++; if ({busy, done, pass} !== 3'b000) $display("FAIL abort_flags got %b want 000", {busy, done, pass}); else n_pass++;
    n_total++; if ({vec_count, err_count, first_err_idx} !== 24'h0 || {first_err_x, first_err_y, first_err_z} !== 12'h0) $display("FAIL abort_clear got %h %h want 000000 000", {vec_count, err_count, first_err_idx}, {first_err_x, first_err_y, first_err_z}); else n_pass++;
    send(2'b00, 4'b0001, 4'b0001, 4'b1111, 1'b1);
    n_total++; if ({busy, done} !== 2'b00 || vec_count !== 8'd0) $display("FAIL abort_idle got busy/done=%b vec=%0d want 00 vec=0", {busy, done}, vec_count); else n_pass++;
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 6; i++) send(2'b00, 4'b0000, 4'b0000, 4'b0001, (i == 5));
    n_total++; if (s_vec !== 2'd3 || s_err !== 2'd3) $display("FAIL sat_counts got vec=%0d err=%0d want vec=3 err=3", s_vec, s_err); else n_pass++;
    n_total++; if (s_idx !== 2'd0 || s_fz !== 4'b0001) $display("FAIL sat_capture got idx=%0d z=%b want idx=0 z=0001", s_idx, s_fz); else n_pass++;
    n_total++; if ({s_done, s_pass} !== 2'b10) $display("FAIL sat_flags got done/pass=%b want 10", {s_done, s_pass}); else n_pass++;
    n_total++; if (vec_count !== 8'd6 || err_count !== 8'd6) $display("FAIL wide_counts got vec=%0d err=%0d want vec=6 err=6", vec_count, err_count); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op = 2'b00; x = '0; y = '0; z = '0;
    test_reset();
    test_or_pass();
    test_error_capture();
    test_add_trunc();
    test_mixed_ops();
    test_restart_rules();
    test_reset_mid_run();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
